// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage in front of a combinational instruction memory. It holds the PC,
// presents it to instruction memory, and captures {PC, instruction} pairs into a
// small FIFO that decode drains through a valid/ready handshake. Redirects
// from branch resolution flush the FIFO and restart fetch at a word-aligned target.
//
// Ports:
//   CLK         clock, rising edge
//   Reset       synchronous active-high reset
//   StartPC     PC loaded on reset
//   IMemAddress instruction memory address (the PC register)
//   IMemData    instruction word returned for IMemAddress
//   InstrOut    instruction at FIFO head (0 when empty)
//   InstrPC     PC of the FIFO head (0 when empty)
//   InstrValid  FIFO head is valid
//   InstrReady  decode accepts the head this cycle
//   Redirect    flush and refetch from RedirectPC
//   RedirectPC  redirect target
//   Misalign    one-cycle pulse: the last redirect target was not word aligned
//   FetchCount  completed handshakes since reset (wraps)
module instruction_fetch_unit #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PC_INC = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [63:0] StartPC,
    output logic [63:0] IMemAddress,
    input  logic [31:0] IMemData,
    output logic [31:0] InstrOut,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic        Misalign,
    output logic [31:0] FetchCount
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      fetch_count;
    logic             misalign_q;

    logic [31:0]      fifo_instr [DEPTH];
    logic [63:0]      fifo_pc    [DEPTH];

    logic             pop;
    logic             push;

    // Handshake and fill decisions; a full FIFO may still accept when it drains this cycle
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        pop  = (count != '0) && InstrReady;
        push = !Redirect && ((count < CNT_W'(DEPTH)) || pop);
    end

    // PC, pointers, occupancy, delivered-count and misalign pulse
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc          <= StartPC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_count <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= Redirect && (RedirectPC[1:0] != 2'b00);
            // Decode consumed the head before any flush, so a pop always counts
            if (pop) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (Redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= {RedirectPC[63:2], 2'b00};
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                    pc   <= pc + 64'(PC_INC);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage; contents are only observed through occupied slots, so no reset
    always_ff @(posedge CLK) begin
        if (!Reset && push) begin
            fifo_instr[tail] <= IMemData;
            fifo_pc[tail]    <= pc;
        end
    end

    // Head read; an empty FIFO presents zeros
    always_comb begin
        InstrValid = 1'b0;
        InstrOut   = '0;
        InstrPC    = '0;
        if (count != '0) begin
            InstrValid = 1'b1;
            InstrOut   = fifo_instr[head];
            InstrPC    = fifo_pc[head];
        end
    end

    assign IMemAddress = pc;
    assign FetchCount  = fetch_count;
    assign Misalign    = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [63:0] StartPC;
    logic [63:0] IMemAddress;
    logic [31:0] IMemData;
    logic [31:0] InstrOut;
    logic [63:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        Misalign;
    logic [31:0] FetchCount;

    int compared   = 0;
    int mismatched = 0;

    instruction_fetch_unit #(.DEPTH(2), .PC_INC(4)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .StartPC    (StartPC),
        .IMemAddress(IMemAddress),
        .IMemData   (IMemData),
        .InstrOut   (InstrOut),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Misalign   (Misalign),
        .FetchCount (FetchCount)
    );

    // Instruction memory image: a few fixed words, otherwise 0x13 in the top byte over the low address bits
    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h0:   imem = 32'hF840_03E9;
            64'h4:   imem = 32'hF840_83EA;
            64'h14:  imem = 32'hAA0B_014A;
            64'h34:  imem = 32'hD2E2_4689;
            default: imem = {8'h13, a[23:0]};
        endcase
    endfunction

    always_comb IMemData = imem(IMemAddress);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling and driving
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        Reset      = 1'b1;
        StartPC    = 64'h0;
        InstrReady = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 64'h0;

        // Sequential stream from 0
        step();
        check("rst_valid", 64'(InstrValid), 64'h0);
        check("rst_instr", 64'(InstrOut), 64'h0);
        check("rst_pc", InstrPC, 64'h0);
        check("rst_fc", 64'(FetchCount), 64'h0);
        check("rst_misalign", 64'(Misalign), 64'h0);
        check("rst_addr", IMemAddress, 64'h0);
        Reset = 1'b0;
        step();
        check("seq_valid", 64'(InstrValid), 64'h1);
        check("seq_pc0", InstrPC, 64'h0);
        check("seq_instr0", 64'(InstrOut), 64'hF840_03E9);
        check("seq_addr", IMemAddress, 64'h4);
        check("seq_fc0", 64'(FetchCount), 64'h0);
        step();
        check("seq_pc4", InstrPC, 64'h4);
        check("seq_instr4", 64'(InstrOut), 64'hF840_83EA);
        check("seq_fc1", 64'(FetchCount), 64'h1);
        for (int k = 2; k <= 5; k++) begin
            step();
            check("seq_pcn", InstrPC, 64'(4 * k));
            check("seq_fcn", 64'(FetchCount), 64'(k));
        end
        check("seq_instr14", 64'(InstrOut), 64'hAA0B_014A);

        // Backpressure from reset
        Reset = 1'b1;
        InstrReady = 1'b0;
        step();
        Reset = 1'b0;
        repeat (5) step();
        check("bp_valid", 64'(InstrValid), 64'h1);
        check("bp_head", InstrPC, 64'h0);
        check("bp_addr", IMemAddress, 64'h8);
        check("bp_fc", 64'(FetchCount), 64'h0);
        InstrReady = 1'b1;
        step();
        check("bp_pc4", InstrPC, 64'h4);
        check("bp_fc1", 64'(FetchCount), 64'h1);
        step();
        check("bp_pc8", InstrPC, 64'h8);
        check("bp_fc2", 64'(FetchCount), 64'h2);
        step();
        check("bp_pcc", InstrPC, 64'hC);
        check("bp_fc3", 64'(FetchCount), 64'h3);

        // Redirect while consuming head 0x28
        repeat (7) step();
        check("rd_head28", InstrPC, 64'h28);
        check("rd_fc_pre", 64'(FetchCount), 64'd10);
        Redirect = 1'b1;
        RedirectPC = 64'h1C;
        step();
        Redirect = 1'b0;
        check("rd_valid0", 64'(InstrValid), 64'h0);
        check("rd_instr0", 64'(InstrOut), 64'h0);
        check("rd_fc_post", 64'(FetchCount), 64'd11);
        check("rd_addr", IMemAddress, 64'h1C);
        check("rd_nomis", 64'(Misalign), 64'h0);
        step();
        check("rd_pc1c", InstrPC, 64'h1C);
        check("rd_instr1c", 64'(InstrOut), 64'h1300_001C);

        // Misaligned redirect
        Redirect = 1'b1;
        RedirectPC = 64'h36;
        step();
        Redirect = 1'b0;
        check("mis_pulse", 64'(Misalign), 64'h1);
        check("mis_addr", IMemAddress, 64'h34);
        check("mis_valid0", 64'(InstrValid), 64'h0);
        check("mis_fc", 64'(FetchCount), 64'd12);
        step();
        check("mis_clear", 64'(Misalign), 64'h0);
        check("mis_pc34", InstrPC, 64'h34);
        check("mis_instr34", 64'(InstrOut), 64'hD2E2_4689);

        // Fill, then reset together with a redirect and a pending pop
        InstrReady = 1'b0;
        repeat (3) step();
        check("full_head", InstrPC, 64'h34);
        check("full_addr", IMemAddress, 64'h3C);
        Reset = 1'b1;
        Redirect = 1'b1;
        RedirectPC = 64'h36;
        StartPC = 64'h100;
        InstrReady = 1'b1;
        step();
        Reset = 1'b0;
        Redirect = 1'b0;
        InstrReady = 1'b0;
        check("rw_valid", 64'(InstrValid), 64'h0);
        check("rw_pc", InstrPC, 64'h0);
        check("rw_addr", IMemAddress, 64'h100);
        check("rw_fc", 64'(FetchCount), 64'h0);
        check("rw_misalign", 64'(Misalign), 64'h0);

        // PC wrap through the top of the address space
        Reset = 1'b1;
        StartPC = 64'hFFFF_FFFF_FFFF_FFF8;
        InstrReady = 1'b1;
        step();
        Reset = 1'b0;
        check("wr_addr", IMemAddress, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("wr_pcf8", InstrPC, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("wr_pcfc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wr_pc0", InstrPC, 64'h0);
        check("wr_instr0", 64'(InstrOut), 64'hF840_03E9);
        step();
        check("wr_pc4", InstrPC, 64'h4);
        check("wr_fc", 64'(FetchCount), 64'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
